// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Two-port register-file write-back arbiter. It grants either
//                the ALU or the memory (load) write-back request, steers the
//                winner through a 32-bit 2:1 mux, and registers the write
//                (latency 1). Ties are broken round robin, and the memory port
//                wins the first tie after reset. Cycles with both ports
//                requesting are counted in a saturating 8-bit counter.
//  Options     : WBARB_R0_DROP_EN - when defined, a granted transfer whose
//                destination is r0 is accepted but does not write.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  // ALU write-back port
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic [4:0]  i_a_rd,
  input  logic [31:0] i_a_data,
  // memory (load) write-back port
  input  logic        i_m_valid,
  output logic        o_m_ready,
  input  logic [4:0]  i_m_rd,
  input  logic [31:0] i_m_data,
  // pipeline freeze
  input  logic        i_stall,
  // register-file write port
  output logic        o_wr_en,
  output logic [4:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_sel,
  output logic [7:0]  o_conflict_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam logic [7:0] c_CNT_MAX = 8'hFF;
  localparam logic [4:0] c_R0      = 5'd0;

  state_t      r_state;
  logic        r_last_gnt_m;   // 1: most recent grant went to memory port
  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_sel;
  logic [7:0]  r_conflict_cnt;

  logic        w_grant_ok;
  logic        w_both;
  logic        w_a_grant;
  logic        w_m_grant;
  logic        w_xfer;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        w_write;

  // Grant decode: single requester wins outright, ties go to the port that
  // did not win last time; reset and stall suppress all grants.
  always_comb begin
    w_grant_ok = !reset && !i_stall;
    w_both     = i_a_valid && i_m_valid;
    w_a_grant  = w_grant_ok && i_a_valid && (!i_m_valid || r_last_gnt_m);
    w_m_grant  = w_grant_ok && i_m_valid && (!i_a_valid || !r_last_gnt_m);
    w_xfer     = w_a_grant || w_m_grant;
  end

  // 32-bit 2:1 write-back mux steered by the memory grant.
  always_comb begin
    w_rd   = w_m_grant ? i_m_rd   : i_a_rd;
    w_data = w_m_grant ? i_m_data : i_a_data;
  end

  // Decide whether the accepted transfer actually writes the register file.
`ifdef WBARB_R0_DROP_EN
  always_comb begin
    w_write = w_xfer && (w_rd != c_R0);
  end
`else
  always_comb begin
    w_write = w_xfer;
  end
`endif

  // Issue FSM with registered write port; non-issuing cycles hold address,
  // data and select so the register file sees stable values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_gnt_m <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 5'd0;
      r_wr_data    <= 32'd0;
      r_sel        <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_last_gnt_m <= w_m_grant;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_write) begin
            r_state   <= ST_ISSUE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_rd;
            r_wr_data <= w_data;
            r_sel     <= w_m_grant;
          end else begin
            r_state   <= ST_IDLE;
            r_wr_en   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (w_write) begin
            r_state   <= ST_ISSUE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_rd;
            r_wr_data <= w_data;
            r_sel     <= w_m_grant;
          end else begin
            r_state   <= ST_IDLE;
            r_wr_en   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where both ports request, stall or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict_cnt <= 8'd0;
    end else if (w_both && (r_conflict_cnt != c_CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  // Drive outputs.
  always_comb begin
    o_a_ready      = w_a_grant;
    o_m_ready      = w_m_grant;
    o_wr_en        = r_wr_en;
    o_wr_addr      = r_wr_addr;
    o_wr_data      = r_wr_data;
    o_sel          = r_sel;
    o_conflict_cnt = r_conflict_cnt;
  end

endmodule
`default_nettype wire
